// File: rtl/mem_stage.sv
// MEM stage of the 5-stage pipeline: word-addressed data memory plus the MEM/WB register.
// An illegal access becomes a bubble, and the first one is recorded in a sticky fault flag and address.
module mem_stage #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] In_Result,
    input  logic [31:0] In_Data,
    input  logic [4:0]  In_Rd,
    input  logic [1:0]  In_MEMControl,
    input  logic [1:0]  In_WBControl,
    input  logic        In_Stall,
    output logic [31:0] Out_ReadData,
    output logic [31:0] Out_ALUResult,
    output logic [4:0]  Out_Rd,
    output logic [1:0]  Out_WBControl,
    output logic        Out_Fault,
    output logic [31:0] Out_FaultAddr
);

    logic [31:0] mem [DEPTH] = '{default: '0};

    logic              mem_write;
    logic              mem_read;
    logic              misaligned;
    logic              out_of_range;
    logic              fault;
    logic [ADDR_W-1:0] index;
    logic [31:0]       read_word;

    always_comb begin
        mem_write    = In_MEMControl[1];
        mem_read     = In_MEMControl[0];
        misaligned   = |In_Result[1:0];
        // Any set bit above the word-index field puts the address past DEPTH*4; no wrap-around.
        out_of_range = (In_Result >> (ADDR_W + 2)) != '0;
        fault        = (mem_read | mem_write) &
                       (misaligned | out_of_range | (mem_read & mem_write));
        index        = In_Result[ADDR_W+1:2];
        read_word    = mem[index];
    end

    always_ff @(posedge Clk) begin
        if (!Rst && !In_Stall && mem_write && !fault)
            mem[index] <= In_Data;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            Out_ReadData  <= '0;
            Out_ALUResult <= '0;
            Out_Rd        <= '0;
            Out_WBControl <= '0;
            Out_Fault     <= 1'b0;
            Out_FaultAddr <= '0;
        end else if (!In_Stall) begin
            Out_ReadData  <= (mem_read && !fault) ? read_word : '0;
            Out_ALUResult <= In_Result;
            Out_Rd        <= In_Rd;
            Out_WBControl <= fault ? 2'b00 : In_WBControl;
            if (fault && !Out_Fault) begin
                Out_Fault     <= 1'b1;
                Out_FaultAddr <= In_Result;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios followed by randomized traffic,
// all checked against an array-based reference model of the stage.
module tb_mem_stage;

    localparam int unsigned DEPTH = 256;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic [31:0] In_Result = '0;
    logic [31:0] In_Data = '0;
    logic [4:0]  In_Rd = '0;
    logic [1:0]  In_MEMControl = '0;
    logic [1:0]  In_WBControl = '0;
    logic        In_Stall = 1'b0;
    logic [31:0] Out_ReadData;
    logic [31:0] Out_ALUResult;
    logic [4:0]  Out_Rd;
    logic [1:0]  Out_WBControl;
    logic        Out_Fault;
    logic [31:0] Out_FaultAddr;

    mem_stage #(.DEPTH(256), .ADDR_W(8)) dut (
        .Clk(Clk), .Rst(Rst), .In_Result(In_Result), .In_Data(In_Data), .In_Rd(In_Rd),
        .In_MEMControl(In_MEMControl), .In_WBControl(In_WBControl), .In_Stall(In_Stall),
        .Out_ReadData(Out_ReadData), .Out_ALUResult(Out_ALUResult), .Out_Rd(Out_Rd),
        .Out_WBControl(Out_WBControl), .Out_Fault(Out_Fault), .Out_FaultAddr(Out_FaultAddr)
    );

    always #5 Clk = ~Clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [31:0] m [DEPTH];
    logic [31:0] e_rdata, e_alu, e_faddr;
    logic [4:0]  e_rd;
    logic [1:0]  e_wb;
    logic        e_fault;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".rdata"}, Out_ReadData, e_rdata);
        chk({tag, ".alu"},   Out_ALUResult, e_alu);
        chk({tag, ".rd"},    {27'd0, Out_Rd}, {27'd0, e_rd});
        chk({tag, ".wb"},    {30'd0, Out_WBControl}, {30'd0, e_wb});
        chk({tag, ".fault"}, {31'd0, Out_Fault}, {31'd0, e_fault});
        chk({tag, ".faddr"}, Out_FaultAddr, e_faddr);
    endtask

    // One clock: drive, let the edge happen, advance the model, then compare.
    task automatic step(input string tag, input logic rst, input logic stall,
                        input logic [31:0] res, input logic [31:0] data,
                        input logic [4:0] rd, input logic [1:0] mc, input logic [1:0] wb);
        bit rdq, wrq, flt;
        Rst = rst; In_Stall = stall; In_Result = res; In_Data = data;
        In_Rd = rd; In_MEMControl = mc; In_WBControl = wb;
        @(posedge Clk);
        rdq = mc[0];
        wrq = mc[1];
        flt = (rdq || wrq) && ((res % 4) != 0 || res >= DEPTH * 4 || (rdq && wrq));
        if (rst) begin
            e_rdata = '0; e_alu = '0; e_rd = '0; e_wb = '0; e_fault = 1'b0; e_faddr = '0;
        end else if (!stall) begin
            e_rdata = (rdq && !flt) ? m[res / 4] : 32'd0;
            if (wrq && !flt) m[res / 4] = data;
            e_alu = res;
            e_rd  = rd;
            e_wb  = flt ? 2'b00 : wb;
            if (flt && !e_fault) begin
                e_fault = 1'b1;
                e_faddr = res;
            end
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [31:0] a;
        for (int i = 0; i < DEPTH; i++) m[i] = '0;
        e_rdata = '0; e_alu = '0; e_rd = '0; e_wb = '0; e_fault = 1'b0; e_faddr = '0;

        step("rst0", 1, 0, 32'h0, 32'h0, 5'd0, 2'b00, 2'b00);
        step("rst1", 1, 0, 32'h0, 32'h0, 5'd0, 2'b00, 2'b00);
        step("st8",  0, 0, 32'd8, 32'hDEADBEEF, 5'd0, 2'b10, 2'b00);
        step("ld8",  0, 0, 32'd8, 32'h0, 5'd9, 2'b01, 2'b11);
        step("alu",  0, 0, 32'h0000000C, 32'h0, 5'd5, 2'b00, 2'b01);
        step("mis6", 0, 0, 32'd6, 32'h0, 5'd3, 2'b01, 2'b11);
        step("st400", 0, 0, 32'h400, 32'hCAFEF00D, 5'd1, 2'b10, 2'b01);
        step("ld0",  0, 0, 32'h0, 32'h0, 5'd2, 2'b01, 2'b11);
        step("rstA", 1, 0, 32'h0, 32'h0, 5'd0, 2'b00, 2'b00);
        step("lastok", 0, 0, (DEPTH - 1) * 4, 32'h0, 5'd4, 2'b01, 2'b11);
        step("oor",  0, 0, DEPTH * 4, 32'h0, 5'd4, 2'b01, 2'b11);
        step("rstB", 1, 0, 32'h0, 32'h0, 5'd0, 2'b00, 2'b00);
        step("wrap", 0, 0, 32'hFFFFFFFC, 32'h0, 5'd4, 2'b01, 2'b11);
        step("rstC", 1, 0, 32'h0, 32'h0, 5'd0, 2'b00, 2'b00);
        step("pre",  0, 0, 32'd16, 32'h0, 5'd7, 2'b00, 2'b01);
        step("stall_st", 0, 1, 32'd1020, 32'h12345678, 5'd8, 2'b10, 2'b00);
        step("stall_flt", 0, 1, 32'd3, 32'h0, 5'd8, 2'b01, 2'b11);
        step("ld1020a", 0, 0, 32'd1020, 32'h0, 5'd8, 2'b01, 2'b11);
        step("st1020", 0, 0, 32'd1020, 32'h12345678, 5'd8, 2'b10, 2'b00);
        step("ld1020b", 0, 0, 32'd1020, 32'h0, 5'd8, 2'b01, 2'b11);
        step("rwrst", 1, 0, 32'd4, 32'h55AA55AA, 5'd6, 2'b11, 2'b11);
        step("ld4",  0, 0, 32'd4, 32'h0, 5'd6, 2'b01, 2'b11);
        step("stallrst", 1, 1, 32'd4, 32'h0, 5'd6, 2'b01, 2'b11);

        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: a = $urandom_range(0, 15) * 4;
                4, 5:       a = $urandom_range(0, DEPTH - 1) * 4;
                6:          a = ($urandom_range(0, DEPTH - 1) * 4) | $urandom_range(1, 3);
                7:          a = DEPTH * 4 + $urandom_range(0, 4095);
                8:          a = 32'hFFFFFFFC;
                default:    a = $urandom;
            endcase
            step("rand", ($urandom_range(0, 99) < 5), ($urandom_range(0, 99) < 20),
                 a, $urandom, 5'($urandom), 2'($urandom), 2'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
